mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller.sv | 93 +++++++++
 tb/tb_mem_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// mem_controller: processor-to-synchronous-RAM bridge with fixed-latency handshake; MEM_BOUNDS_CHECK_EN enables out-of-range detection
module mem_controller #(
  parameter int ADDR_W = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [31:0]       iMemAddr,
  input  logic [31:0]       iMemData,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  output logic [31:0]       oMemData,
  output logic              oMemRdy,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [31:0]       oRamData,
  input  logic [31:0]       iRamData,
  output logic              oRamEn,
  output logic              oRamWe,
  output logic              oBusErr
);
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d, err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic req, oob;
  assign req = iMemRead | iMemWrite;
`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = |(iMemAddr >> ADDR_W);
`else
  logic unused_upper;
  assign unused_upper = ^(iMemAddr >> ADDR_W);
  assign oob = 1'b0;
`endif
  // state and transaction latches; everything clears on reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q <= we_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  // next-state: one access, capture, optional wait run, then hold DONE while requested
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = req ? S_ACCESS : S_IDLE;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = WAIT_STATES > 0 ? S_WAIT : S_DONE;
      S_WAIT:    state_d = cnt_q == 4'(WAIT_STATES - 1) ? S_DONE : S_WAIT;
      S_DONE:    state_d = req ? S_DONE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end
  // datapath: latch request only in IDLE (write wins over read), capture RAM data on reads
  always_comb begin
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    err_d = err_q;
    if (state_q == S_IDLE && req) begin
      addr_d = iMemAddr[ADDR_W-1:0];
      wdata_d = iMemData;
      we_d = iMemWrite;
      err_d = oob;
    end
    rdata_d = (state_q == S_CAPTURE && !we_q) ? iRamData : rdata_q;
    cnt_d = state_q == S_WAIT ? cnt_q + 4'd1 : 4'd0;
  end
  // outputs decoded from state; an out-of-range access suppresses the RAM strobe
  always_comb begin
    oRamEn = state_q == S_ACCESS && !err_q;
    oRamWe = oRamEn && we_q;
    oRamAddr = addr_q;
    oRamData = wdata_q;
    oMemRdy = state_q == S_DONE;
    oMemData = (oMemRdy && !we_q && !err_q) ? rdata_q : 32'd0;
    oBusErr = oMemRdy && err_q;
  end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: randomized transaction-level check of mem_controller against a reference memory
module tb_mem_controller;
  localparam int AW = 8;
  localparam int WS = 2;
  logic iClk = 1'b0, iRst = 1'b1;
  logic [31:0] iMemAddr = '0, iMemData = '0, iRamData = '0;
  logic iMemRead = 1'b0, iMemWrite = 1'b0;
  logic [31:0] oMemData, oRamData;
  logic [AW-1:0] oRamAddr;
  logic oMemRdy, oRamEn, oRamWe, oBusErr;
  int n_checks = 0, n_errors = 0;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int en_cnt = 0;
  logic [AW-1:0] last_addr;
  logic [31:0] last_data;
  logic last_we;

  mem_controller #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .iClk(iClk), .iRst(iRst), .iMemAddr(iMemAddr), .iMemData(iMemData),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .oMemData(oMemData),
    .oMemRdy(oMemRdy), .oRamAddr(oRamAddr), .oRamData(oRamData),
    .iRamData(iRamData), .oRamEn(oRamEn), .oRamWe(oRamWe), .oBusErr(oBusErr)
  );

  always #5 iClk = ~iClk;

  // synchronous RAM model plus access monitor
  always @(posedge iClk) begin
    if (oRamEn) begin
      en_cnt++;
      last_addr = oRamAddr;
      last_data = oRamData;
      last_we = oRamWe;
      if (oRamWe) ram[oRamAddr] <= oRamData;
      else iRamData <= ram[oRamAddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic out_of_range(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return |a[31:AW];
`else
    return a[31] & 1'b0;
`endif
  endfunction

  // mode 0: hold request `hold` cycles past ready; 1: drop right after sampling; 2: scramble inputs after sampling
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input int mode, input int hold);
    logic oob;
    logic [7:0] ea;
    logic [31:0] exp_d;
    int lat;
    ea = a[7:0];
    oob = out_of_range(a);
    if (wr && !oob) ref_mem[ea] = d;
    exp_d = (wr || oob) ? 32'd0 : ref_mem[ea];
    @(negedge iClk);
    en_cnt = 0;
    iMemRead = rd; iMemWrite = wr; iMemAddr = a; iMemData = d;
    lat = 0;
    do begin
      @(posedge iClk); #1;
      lat++;
      if (lat == 1 && mode == 1) begin
        iMemRead = 1'b0; iMemWrite = 1'b0;
      end else if (lat == 1 && mode == 2) begin
        iMemAddr = $urandom; iMemData = $urandom; iMemRead = 1'b1; iMemWrite = 1'($urandom_range(0, 1));
      end
    end while (!oMemRdy && lat < 30);
    check("latency", 32'(lat), 32'(WS + 3));
    check("rdata", oMemData, exp_d);
    check("buserr", {31'd0, oBusErr}, {31'd0, oob});
    check("ram_access_count", 32'(en_cnt), oob ? 32'd0 : 32'd1);
    if (!oob && en_cnt == 1) begin
      check("ram_we", {31'd0, last_we}, {31'd0, wr});
      check("ram_addr", {24'd0, last_addr}, {24'd0, ea});
      if (wr) check("ram_wdata", last_data, d);
    end
    if (mode != 1) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge iClk); #1;
        check("rdy_held", {31'd0, oMemRdy}, 32'd1);
      end
      @(negedge iClk);
      iMemRead = 1'b0; iMemWrite = 1'b0;
    end
    @(posedge iClk); #1;
    check("rdy_cleared", {31'd0, oMemRdy}, 32'd0);
    check("single_access", 32'(en_cnt), oob ? 32'd0 : 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {oMemData, oRamData, 24'd0, oRamAddr, 28'd0, oMemRdy, oRamEn, oRamWe, oBusErr} == '0 ? 32'd0 : 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int seen_rdy;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    repeat (2) @(posedge iClk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge iClk);
    iRst = 1'b0;
    txn(1'b0, 1'b1, 32'd5, 32'h37, 0, 0);
    txn(1'b1, 1'b0, 32'd5, 32'h0, 0, 0);
    txn(1'b1, 1'b1, 32'd3, 32'hAA, 0, 0);
    txn(1'b1, 1'b0, 32'd3, 32'h0, 0, 10);
    txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 0);
    txn(1'b0, 1'b1, 32'h200, 32'h1234_5678, 1, 0);
    txn(1'b1, 1'b0, 32'h0, 32'h0, 2, 2);
    // reset during the wait phase aborts without a ready pulse
    @(negedge iClk);
    iMemRead = 1'b1; iMemAddr = 32'd7;
    seen_rdy = 0;
    repeat (3) begin
      @(posedge iClk); #1;
      if (oMemRdy) seen_rdy++;
    end
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk); #1;
    check_all_zero("reset_mid_wait");
    @(negedge iClk);
    iRst = 1'b0; iMemRead = 1'b0;
    repeat (6) begin
      @(posedge iClk); #1;
      if (oMemRdy) seen_rdy++;
    end
    check("no_rdy_after_abort", 32'(seen_rdy), 32'd0);
    txn(1'b1, 1'b0, 32'd7, 32'h0, 0, 0);
    // reset landing on the write strobe edge still commits the write
    @(negedge iClk);
    en_cnt = 0;
    iMemWrite = 1'b1; iMemAddr = 32'd9; iMemData = 32'hDEAD_BEEF;
    @(posedge iClk); #1;
    @(negedge iClk);
    iRst = 1'b1; iMemWrite = 1'b0;
    @(posedge iClk); #1;
    check("reset_commit_access", 32'(en_cnt), 32'd1);
    check_all_zero("reset_on_access");
    ref_mem[9] = 32'hDEAD_BEEF;
    @(negedge iClk);
    iRst = 1'b0;
    txn(1'b1, 1'b0, 32'd9, 32'h0, 0, 0);
    for (int k = 0; k < 80; k++) begin
      logic r, w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      a = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 15));
      txn(r, w, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
